// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the two-port memory arbiter.
// Build option: ARB_ROUND_ROBIN_EN selects round-robin instead of fixed priority.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_DONE  = 2'd3
    } arb_state_t;

    localparam int PORT_I = 0;
    localparam int PORT_D = 1;

    function automatic int line_width(input int block_size);
        return block_size * 8;
    endfunction

endpackage

// File: rtl/mem_arb_pick.sv
// Two-way grant selection, one-hot result.
// Build option: ARB_ROUND_ROBIN_EN adds the favour input (port to prefer on a tie).
module mem_arb_pick
    import mem_arb_pkg::*;
(
    input  logic       valid0,
    input  logic       valid1,
`ifdef ARB_ROUND_ROBIN_EN
    input  logic       favour,
`endif
    output logic [1:0] grant
);

    always_comb begin
        grant = 2'b00;
        if (valid0 && valid1) begin
`ifdef ARB_ROUND_ROBIN_EN
            grant[favour] = 1'b1;
`else
            grant[PORT_D] = 1'b1;
`endif
        end else begin
            grant = {valid1, valid0};
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates I-cache and D-cache line requests onto one memory port.
// Build option: ARB_ROUND_ROBIN_EN enables round-robin tie breaking.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter  int BLOCK_SIZE    = 16,
    parameter  int MEM_LATENCY_W = 8,
    localparam int LW            = line_width(BLOCK_SIZE)
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     req0_valid,
    input  logic [31:0]              req0_addr,
    input  logic                     req0_read,
    input  logic                     req0_write,
    input  logic [LW-1:0]            req0_din,
    input  logic                     req1_valid,
    input  logic [31:0]              req1_addr,
    input  logic                     req1_read,
    input  logic                     req1_write,
    input  logic [LW-1:0]            req1_din,
    output logic                     req0_grant,
    output logic                     req0_done,
    output logic                     req1_grant,
    output logic                     req1_done,
    output logic [LW-1:0]            resp_dout,
    output logic                     mem_is_input_valid,
    output logic                     mem_read,
    output logic                     mem_write,
    output logic [31:0]              mem_addr,
    output logic [LW-1:0]            mem_din,
    input  logic                     mem_ready,
    input  logic                     mem_output_valid,
    input  logic [LW-1:0]            mem_dout,
    output logic                     busy,
    output logic [MEM_LATENCY_W-1:0] last_latency
);

    arb_state_t               state;
    logic                     owner;
    logic                     lat_read;
    logic                     lat_write;
    logic [31:0]              lat_addr;
    logic [LW-1:0]            lat_din;
    logic [MEM_LATENCY_W-1:0] cnt;
    logic [MEM_LATENCY_W-1:0] cnt_inc;
    logic                     ok0;
    logic                     ok1;
    logic [1:0]               pick;

    // A request is only eligible when it names exactly one operation.
    assign ok0 = req0_valid && (req0_read ^ req0_write);
    assign ok1 = req1_valid && (req1_read ^ req1_write);

`ifdef ARB_ROUND_ROBIN_EN
    logic favour;

    mem_arb_pick u_pick (
        .valid0 (ok0),
        .valid1 (ok1),
        .favour (favour),
        .grant  (pick)
    );
`else
    mem_arb_pick u_pick (
        .valid0 (ok0),
        .valid1 (ok1),
        .grant  (pick)
    );
`endif

    assign cnt_inc = (&cnt) ? cnt : cnt + 1'b1;

    assign mem_is_input_valid = (state == S_ISSUE) && mem_ready;
    assign mem_read           = mem_is_input_valid && lat_read;
    assign mem_write          = mem_is_input_valid && lat_write;
    assign mem_addr           = lat_addr;
    assign mem_din            = lat_din;
    assign busy               = (state != S_IDLE);

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= S_IDLE;
            owner        <= 1'b0;
            lat_read     <= 1'b0;
            lat_write    <= 1'b0;
            lat_addr     <= '0;
            lat_din      <= '0;
            cnt          <= '0;
            req0_grant   <= 1'b0;
            req1_grant   <= 1'b0;
            req0_done    <= 1'b0;
            req1_done    <= 1'b0;
            resp_dout    <= '0;
            last_latency <= '0;
`ifdef ARB_ROUND_ROBIN_EN
            favour       <= 1'b0;
`endif
        end else begin
            req0_grant <= 1'b0;
            req1_grant <= 1'b0;
            req0_done  <= 1'b0;
            req1_done  <= 1'b0;
            unique case (state)
                S_IDLE: begin
                    if (|pick) begin
                        owner      <= pick[1];
                        lat_read   <= pick[1] ? req1_read  : req0_read;
                        lat_write  <= pick[1] ? req1_write : req0_write;
                        lat_addr   <= pick[1] ? req1_addr  : req0_addr;
                        lat_din    <= pick[1] ? req1_din   : req0_din;
                        cnt        <= '0;
                        req0_grant <= pick[0];
                        req1_grant <= pick[1];
`ifdef ARB_ROUND_ROBIN_EN
                        favour     <= ~pick[1];
`endif
                        state      <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    cnt <= cnt_inc;
                    if (mem_ready) state <= S_WAIT;
                end
                S_WAIT: begin
                    cnt <= cnt_inc;
                    // Reads finish on returned data, writes on the next ready.
                    if (lat_read ? mem_output_valid : mem_ready) begin
                        if (lat_read) resp_dout <= mem_dout;
                        last_latency <= cnt_inc;
                        req0_done    <= ~owner;
                        req1_done    <= owner;
                        state        <= S_DONE;
                    end
                end
                S_DONE: begin
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed scenarios plus a
// randomized run against a transaction-level reference model.
module tb_mem_arbiter;

    localparam int LW = 128;
    localparam logic [LW-1:0] PAT_A = {8{16'hAAAA}};
    localparam logic [LW-1:0] PAT_5 = {16{8'h55}};

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          req0_valid = 1'b0;
    logic [31:0]   req0_addr = '0;
    logic          req0_read = 1'b0;
    logic          req0_write = 1'b0;
    logic [LW-1:0] req0_din = '0;
    logic          req1_valid = 1'b0;
    logic [31:0]   req1_addr = '0;
    logic          req1_read = 1'b0;
    logic          req1_write = 1'b0;
    logic [LW-1:0] req1_din = '0;
    logic          req0_grant, req0_done, req1_grant, req1_done;
    logic [LW-1:0] resp_dout;
    logic          mem_is_input_valid, mem_read, mem_write;
    logic [31:0]   mem_addr;
    logic [LW-1:0] mem_din;
    logic          mem_ready = 1'b1;
    logic          mem_output_valid = 1'b0;
    logic [LW-1:0] mem_dout = '0;
    logic          busy;
    logic [7:0]    last_latency;

    int errors = 0;
    int checks = 0;
    int cyc_n = 0;

    mem_arbiter #(.BLOCK_SIZE(16), .MEM_LATENCY_W(8)) dut (
        .clk(clk), .reset(reset),
        .req0_valid(req0_valid), .req0_addr(req0_addr), .req0_read(req0_read),
        .req0_write(req0_write), .req0_din(req0_din),
        .req1_valid(req1_valid), .req1_addr(req1_addr), .req1_read(req1_read),
        .req1_write(req1_write), .req1_din(req1_din),
        .req0_grant(req0_grant), .req0_done(req0_done),
        .req1_grant(req1_grant), .req1_done(req1_done),
        .resp_dout(resp_dout),
        .mem_is_input_valid(mem_is_input_valid), .mem_read(mem_read),
        .mem_write(mem_write), .mem_addr(mem_addr), .mem_din(mem_din),
        .mem_ready(mem_ready), .mem_output_valid(mem_output_valid),
        .mem_dout(mem_dout),
        .busy(busy), .last_latency(last_latency)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
        cyc_n++;
    endtask

    task automatic idle_inputs();
        req0_valid = 1'b0; req0_read = 1'b0; req0_write = 1'b0;
        req1_valid = 1'b0; req1_read = 1'b0; req1_write = 1'b0;
        mem_ready = 1'b1;
        mem_output_valid = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        idle_inputs();
        step();
        step();
        reset = 1'b0;
    endtask

    task automatic set_port(input int p, input logic v, input logic r,
                            input logic wr, input logic [31:0] a,
                            input logic [LW-1:0] d);
        if (p == 0) begin
            req0_valid = v; req0_read = r; req0_write = wr;
            req0_addr = a; req0_din = d;
        end else begin
            req1_valid = v; req1_read = r; req1_write = wr;
            req1_addr = a; req1_din = d;
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        set_port(0, 1'b1, 1'b1, 1'b0, 32'h40, PAT_A);
        set_port(1, 1'b1, 1'b0, 1'b1, 32'h80, PAT_5);
        mem_output_valid = 1'b1;
        mem_dout = PAT_A;
        repeat (3) step();
        checks++;
        if ({req0_grant, req1_grant, req0_done, req1_done, mem_is_input_valid,
             mem_read, mem_write, busy} !== 8'h00)
            begin errors++; $display("FAIL reset_ctrl got=%b%b%b%b%b%b%b%b required=0",
                req0_grant, req1_grant, req0_done, req1_done, mem_is_input_valid,
                mem_read, mem_write, busy); end
        checks++;
        if (mem_addr !== 32'h0 || last_latency !== 8'h0)
            begin errors++; $display("FAIL reset_addr_lat got=%h/%h required=0/0",
                mem_addr, last_latency); end
        checks++;
        if (mem_din !== '0 || resp_dout !== '0)
            begin errors++; $display("FAIL reset_data got=%h/%h required=0",
                mem_din, resp_dout); end
        reset = 1'b0;
        idle_inputs();
        step();
        checks++;
        if ({busy, req0_grant, req1_grant} !== 3'b000)
            begin errors++; $display("FAIL reset_release got=%b%b%b required=000",
                busy, req0_grant, req1_grant); end
    endtask

    task automatic test_read_basic();
        int n_grant = 0;
        int n_issue = 0;
        int since = -1;
        bit got = 1'b0;
        idle_inputs();
        set_port(0, 1'b1, 1'b1, 1'b0, 32'h10, '0);
        for (int i = 0; i < 20 && !got; i++) begin
            step();
            mem_output_valid = 1'b0;
            if (req0_grant) n_grant++;
            if (req1_grant || req1_done) begin
                errors++; $display("FAIL read_basic_port1 got=%b%b required=00",
                    req1_grant, req1_done);
            end
            if (req0_done) begin
                got = 1'b1;
                req0_valid = 1'b0;
                checks++;
                if (resp_dout !== PAT_A)
                    begin errors++; $display("FAIL read_basic_resp got=%h required=%h",
                        resp_dout, PAT_A); end
                checks++;
                if (last_latency !== 8'd4)
                    begin errors++; $display("FAIL read_basic_latency got=%0d required=4",
                        last_latency); end
            end
            if (mem_is_input_valid) begin
                n_issue++;
                since = 0;
                checks++;
                if (mem_read !== 1'b1 || mem_write !== 1'b0 || mem_addr !== 32'h10)
                    begin errors++; $display("FAIL read_basic_cmd got=%b%b/%h required=10/10",
                        mem_read, mem_write, mem_addr); end
            end else if (since >= 0) begin
                since++;
            end
            if (since == 3) begin
                mem_output_valid = 1'b1;
                mem_dout = PAT_A;
            end
        end
        checks++;
        if (!got || n_grant != 1 || n_issue != 1)
            begin errors++; $display("FAIL read_basic_counts got done=%0d grants=%0d issues=%0d required=1/1/1",
                got, n_grant, n_issue); end
        idle_inputs();
    endtask

    task automatic test_write_stall();
        int n_issue = 0;
        bit stall_bad = 1'b0;
        bit got = 1'b0;
        idle_inputs();
        step();
        step();
        mem_ready = 1'b0;
        set_port(1, 1'b1, 1'b0, 1'b1, 32'h22, PAT_5);
        for (int i = 1; i <= 20 && !got; i++) begin
            step();
            if (i == 1) begin
                checks++;
                if (req1_grant !== 1'b1 || req0_grant !== 1'b0)
                    begin errors++; $display("FAIL write_grant got=%b%b required=10",
                        req1_grant, req0_grant); end
                req1_addr = 32'hDEAD_BEEF;
                req1_din = ~PAT_5;
            end
            if (req1_done) begin
                got = 1'b1;
                req1_valid = 1'b0;
                checks++;
                if (last_latency !== 8'd7 || i != 8)
                    begin errors++; $display("FAIL write_latency got=%0d at cycle %0d required=7 at 8",
                        last_latency, i); end
            end
            if (i == 6) mem_ready = 1'b1;
            #1;
            if (i < 6 && (mem_is_input_valid || busy !== 1'b1)) stall_bad = 1'b1;
            if (mem_is_input_valid) begin
                n_issue++;
                checks++;
                if (mem_write !== 1'b1 || mem_read !== 1'b0 || mem_addr !== 32'h22
                    || mem_din !== PAT_5 || i != 6)
                    begin errors++; $display("FAIL write_cmd got=%b%b/%h/%h cycle %0d required=01/22/%h cycle 6",
                        mem_read, mem_write, mem_addr, mem_din, i, PAT_5); end
            end
        end
        checks++;
        if (!got || n_issue != 1 || stall_bad)
            begin errors++; $display("FAIL write_stall got done=%0d issues=%0d stall_bad=%0d required=1/1/0",
                got, n_issue, stall_bad); end
        idle_inputs();
    endtask

    task automatic test_illegal_drop();
        bit bad = 1'b0;
        bit got = 1'b0;
        logic [LW-1:0] data;
        idle_inputs();
        step();
        step();
        set_port(0, 1'b1, 1'b1, 1'b1, 32'h33, '0);
        repeat (6) begin
            step();
            if (req0_grant || req1_grant || busy) bad = 1'b1;
        end
        req0_read = 1'b0;
        req0_write = 1'b0;
        repeat (6) begin
            step();
            if (req0_grant || req1_grant || busy) bad = 1'b1;
        end
        checks++;
        if (bad) begin errors++; $display("FAIL illegal_cmd got=granted/busy required=ignored"); end
        set_port(0, 1'b1, 1'b1, 1'b0, 32'h77, '0);
        step();
        checks++;
        if (req0_grant !== 1'b1)
            begin errors++; $display("FAIL drop_grant got=%b required=1", req0_grant); end
        req0_valid = 1'b0;
        req0_addr = 32'hFFFF_FFFF;
        data = {4{$urandom}};
        step();
        mem_output_valid = 1'b1;
        mem_dout = data;
        for (int i = 0; i < 12 && !got; i++) begin
            step();
            mem_output_valid = 1'b0;
            if (req0_done) got = 1'b1;
        end
        checks++;
        if (!got || resp_dout !== data)
            begin errors++; $display("FAIL drop_done got=%0d/%h required=1/%h",
                got, resp_dout, data); end
        idle_inputs();
    endtask

    task automatic test_saturation();
        idle_inputs();
        step();
        step();
        set_port(0, 1'b1, 1'b1, 1'b0, 32'h5, '0);
        repeat (300) step();
        mem_output_valid = 1'b1;
        mem_dout = PAT_5;
        step();
        mem_output_valid = 1'b0;
        req0_valid = 1'b0;
        checks++;
        if (req0_done !== 1'b1 || last_latency !== 8'hFF || resp_dout !== PAT_5)
            begin errors++; $display("FAIL saturation got=%b/%0d/%h required=1/255/%h",
                req0_done, last_latency, resp_dout, PAT_5); end
        idle_inputs();
    endtask

    task automatic test_simultaneous();
        int order[$];
        int gt[$];
        int since = -1;
        int first;
        bit d0 = 1'b0;
        bit d1 = 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
        first = 0;
`else
        first = 1;
`endif
        do_reset();
        set_port(0, 1'b1, 1'b1, 1'b0, 32'h100, '0);
        set_port(1, 1'b1, 1'b1, 1'b0, 32'h200, '0);
        for (int i = 0; i < 60 && !(d0 && d1); i++) begin
            step();
            mem_output_valid = 1'b0;
            if (req0_done) begin d0 = 1'b1; req0_valid = 1'b0; end
            if (req1_done) begin d1 = 1'b1; req1_valid = 1'b0; end
            if (req0_grant) begin order.push_back(0); gt.push_back(cyc_n); end
            if (req1_grant) begin order.push_back(1); gt.push_back(cyc_n); end
            #1;
            if (mem_is_input_valid) since = 0;
            else if (since >= 0) since++;
            if (since == 1) begin
                mem_output_valid = 1'b1;
                mem_dout = {4{$urandom}};
                since = -1;
            end
        end
        checks++;
        if (!(d0 && d1) || order.size() != 2) begin
            errors++; $display("FAIL simul_count got done=%0d%0d grants=%0d required=11/2",
                d0, d1, order.size());
        end else begin
            checks++;
            if (order[0] != first || order[1] != 1 - first)
                begin errors++; $display("FAIL simul_order got=%0d,%0d required=%0d,%0d",
                    order[0], order[1], first, 1 - first); end
            checks++;
            if (gt[1] - gt[0] != 4)
                begin errors++; $display("FAIL simul_spacing got=%0d required=4",
                    gt[1] - gt[0]); end
        end
        idle_inputs();
    endtask

    task automatic test_reset_mid();
        bit bad = 1'b0;
        bit got = 1'b0;
        do_reset();
        set_port(0, 1'b1, 1'b1, 1'b0, 32'h30, '0);
        step();
        checks++;
        if (req0_grant !== 1'b1)
            begin errors++; $display("FAIL rmid_grant got=%b required=1", req0_grant); end
        step();
        checks++;
        if (busy !== 1'b1)
            begin errors++; $display("FAIL rmid_busy got=%b required=1", busy); end
        reset = 1'b1;
        req0_valid = 1'b0;
        step();
        step();
        reset = 1'b0;
        mem_output_valid = 1'b1;
        mem_dout = PAT_A;
        repeat (3) begin
            step();
            if ({req0_grant, req1_grant, req0_done, req1_done, mem_is_input_valid,
                 mem_read, mem_write, busy} !== 8'h00) bad = 1'b1;
            if (mem_addr !== 32'h0 || mem_din !== '0 || resp_dout !== '0
                || last_latency !== 8'h0) bad = 1'b1;
        end
        checks++;
        if (bad) begin errors++; $display("FAIL rmid_quiet got=activity required=all outputs 0"); end
        mem_output_valid = 1'b0;
        set_port(1, 1'b1, 1'b0, 1'b1, 32'h44, PAT_5);
        for (int i = 0; i < 10 && !got; i++) begin
            step();
            if (req1_done) begin got = 1'b1; req1_valid = 1'b0; end
        end
        checks++;
        if (!got || last_latency !== 8'd2 || resp_dout !== '0)
            begin errors++; $display("FAIL rmid_next got=%0d/%0d/%h required=1/2/0",
                got, last_latency, resp_dout); end
        idle_inputs();
    endtask

    task automatic test_random();
        bit pend[2];
        bit pr[2];
        logic [31:0] pa[2];
        logic [LW-1:0] pd[2];
        bit act = 1'b0;
        bit fin = 1'b0;
        bit due = 1'b0;
        bit due_now;
        bit issued = 1'b0;
        bit exp_issue;
        bit c_r = 1'b0;
        bit b;
        int own = 0;
        int gcyc = 0;
        int issue_t = 0;
        int last_g = 1;
        int w;
        int exp_lat = 0;
        int ndone = 0;
        logic [31:0] c_a = '0;
        logic [LW-1:0] c_d = '0;
        logic [LW-1:0] ret = '0;
        logic [LW-1:0] exp_resp = '0;
        logic [1:0] eg;
        logic [1:0] ed;
        logic [2:0] ecmd;
        pend[0] = 1'b0;
        pend[1] = 1'b0;
        do_reset();
        for (int i = 0; i < 800; i++) begin
            step();
            eg = 2'b00;
            w = 0;
            if (!act && (pend[0] || pend[1])) begin
                if (pend[0] && pend[1]) begin
`ifdef ARB_ROUND_ROBIN_EN
                    w = (last_g == 0) ? 1 : 0;
`else
                    w = 1;
`endif
                end else begin
                    w = pend[1] ? 1 : 0;
                end
                eg[w] = 1'b1;
            end
            checks++;
            if ({req1_grant, req0_grant} !== eg)
                begin errors++; $display("FAIL rnd_grant cycle %0d got=%b%b required=%b",
                    cyc_n, req1_grant, req0_grant, eg); end
            if (fin) begin act = 1'b0; fin = 1'b0; end
            due_now = due;
            due = 1'b0;
            ed = 2'b00;
            if (due_now) begin
                ed[own] = 1'b1;
                fin = 1'b1;
                ndone++;
                if (c_r) exp_resp = ret;
                exp_lat = (cyc_n - gcyc > 255) ? 255 : cyc_n - gcyc;
            end
            checks++;
            if ({req1_done, req0_done} !== ed)
                begin errors++; $display("FAIL rnd_done cycle %0d got=%b%b required=%b",
                    cyc_n, req1_done, req0_done, ed); end
            checks++;
            if (resp_dout !== exp_resp)
                begin errors++; $display("FAIL rnd_resp cycle %0d got=%h required=%h",
                    cyc_n, resp_dout, exp_resp); end
            checks++;
            if (last_latency !== 8'(exp_lat))
                begin errors++; $display("FAIL rnd_latency cycle %0d got=%0d required=%0d",
                    cyc_n, last_latency, exp_lat); end
            if (eg != 2'b00) begin
                act = 1'b1; own = w; gcyc = cyc_n; issued = 1'b0;
                c_r = pr[w]; c_a = pa[w]; c_d = pd[w];
                pend[w] = 1'b0; last_g = w;
            end
            checks++;
            if (busy !== act)
                begin errors++; $display("FAIL rnd_busy cycle %0d got=%b required=%b",
                    cyc_n, busy, act); end
            for (int p = 0; p < 2; p++) begin
                if (act && own == p) begin
                    b = 1'($urandom_range(1));
                    set_port(p, 1'($urandom_range(1)), b, b, $urandom, {4{$urandom}});
                end else begin
                    if (!pend[p] && $urandom_range(2) == 0) begin
                        pend[p] = 1'b1;
                        pr[p] = 1'($urandom_range(1));
                        pa[p] = $urandom;
                        pd[p] = {4{$urandom}};
                    end
                    if (pend[p]) begin
                        set_port(p, 1'b1, pr[p], ~pr[p], pa[p], pd[p]);
                    end else begin
                        b = 1'($urandom_range(1));
                        set_port(p, 1'($urandom_range(1)), b, b, $urandom, {4{$urandom}});
                    end
                end
            end
            mem_ready = 1'($urandom_range(1));
            mem_dout = {4{$urandom}};
            if (act && !fin && issued && c_r)
                mem_output_valid = ($urandom_range(2) == 0);
            else if (!act || (!fin && issued && !c_r))
                mem_output_valid = ($urandom_range(3) == 0);
            else
                mem_output_valid = 1'b0;
            #1;
            exp_issue = act && !fin && !issued && mem_ready;
            ecmd = exp_issue ? {1'b1, c_r, ~c_r} : 3'b000;
            checks++;
            if ({mem_is_input_valid, mem_read, mem_write} !== ecmd)
                begin errors++; $display("FAIL rnd_issue cycle %0d got=%b%b%b required=%b",
                    cyc_n, mem_is_input_valid, mem_read, mem_write, ecmd); end
            if (exp_issue) begin
                checks++;
                if (mem_addr !== c_a || mem_din !== c_d)
                    begin errors++; $display("FAIL rnd_cmd cycle %0d got=%h/%h required=%h/%h",
                        cyc_n, mem_addr, mem_din, c_a, c_d); end
                issued = 1'b1;
                issue_t = cyc_n;
            end else if (act && !fin && issued && issue_t < cyc_n) begin
                if (c_r ? mem_output_valid : mem_ready) begin
                    due = 1'b1;
                    ret = mem_dout;
                end
            end
        end
        checks++;
        if (ndone < 20)
            begin errors++; $display("FAIL rnd_activity got=%0d completions required>=20", ndone); end
        idle_inputs();
    endtask

    initial begin
        test_reset();
        test_read_basic();
        test_write_stall();
        test_illegal_drop();
        test_saturation();
        test_simultaneous();
        test_reset_mid();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
